// File: rtl/hilo_ctrl.sv
// rtl/hilo_ctrl.sv - HI/LO pair owner with 2-cycle multiply and radix-2 restoring divide sequencer
// Optional: DIV_ZERO_FAST_EN retires divide-by-zero in one cycle with hilo unchanged.
module hilo_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        stall,
  output logic        done,
  output logic [63:0] hilo
);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t      state_q, state_d;
  logic [63:0] hilo_q, hilo_d;
  logic        done_q, done_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic        sgn_q, sgn_d;
  logic        negq_q, negq_d;
  logic        negr_q, negr_d;
  logic [63:0] rq_q, rq_d;

  logic        accept;
  logic        op_signed_div;
  logic [31:0] abs_a, abs_b;
  logic [63:0] mul_a, mul_b, prod;
  logic [32:0] trial;
  logic [63:0] step;
  logic [31:0] quot_fix, rem_fix;

  assign accept        = (state_q == IDLE) && req && !done_q && !flush;
  assign op_signed_div = (op == 3'd2);
  assign abs_a         = (op_signed_div && a[31]) ? (32'd0 - a) : a;
  assign abs_b         = (op_signed_div && b[31]) ? (32'd0 - b) : b;

  // Low 64 bits of the product are the same for signed and unsigned once operands are extended.
  assign mul_a = {{32{sgn_q & opa_q[31]}}, opa_q};
  assign mul_b = {{32{sgn_q & opb_q[31]}}, opb_q};
  assign prod  = mul_a * mul_b;

  // One restoring step: shifted remainder needs 33 bits because it can reach 2*divisor-1.
  assign trial    = rq_q[63:31] - {1'b0, opb_q};
  assign step     = trial[32] ? {rq_q[62:0], 1'b0} : {trial[31:0], rq_q[30:0], 1'b1};
  assign quot_fix = negq_q ? (32'd0 - step[31:0])  : step[31:0];
  assign rem_fix  = negr_q ? (32'd0 - step[63:32]) : step[63:32];

  always_comb begin
    state_d = state_q;
    hilo_d  = hilo_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sgn_d   = sgn_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    rq_d    = rq_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          case (op)
            3'd0, 3'd1: begin
              opa_d   = a;
              opb_d   = b;
              sgn_d   = (op == 3'd0);
              state_d = MUL;
            end
            3'd2, 3'd3: begin
              opb_d  = abs_b;
              rq_d   = {32'd0, abs_a};
              negq_d = op_signed_div && (a[31] ^ b[31]);
              negr_d = op_signed_div && a[31];
              cnt_d  = 5'd0;
`ifdef DIV_ZERO_FAST_EN
              if (b == 32'd0) begin
                done_d = 1'b1;
              end else begin
                state_d = DIV;
              end
`else
              state_d = DIV;
`endif
            end
            3'd4:    hilo_d[63:32] = a;
            3'd5:    hilo_d[31:0]  = a;
            default: ;
          endcase
        end
      end
      MUL: begin
        hilo_d  = prod;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      DIV: begin
        rq_d  = step;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          hilo_d  = {rem_fix, quot_fix};
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d = IDLE;
      done_d  = 1'b0;
      cnt_d   = 5'd0;
      hilo_d  = hilo_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      hilo_q  <= 64'd0;
      done_q  <= 1'b0;
      cnt_q   <= 5'd0;
      opa_q   <= 32'd0;
      opb_q   <= 32'd0;
      sgn_q   <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      rq_q    <= 64'd0;
    end else begin
      state_q <= state_d;
      hilo_q  <= hilo_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sgn_q   <= sgn_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      rq_q    <= rq_d;
    end
  end

  assign stall = !flush && ((req && (op <= 3'd3) && (state_q == IDLE) && !done_q) ||
                            (state_q != IDLE));
  assign done  = done_q;
  assign hilo  = hilo_q;

endmodule

// File: tb/tb_hilo_ctrl.sv
// tb/tb_hilo_ctrl.sv - directed self-checking bench for hilo_ctrl
module tb_hilo_ctrl;
  logic        clk;
  logic        resetn;
  logic        req;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        stall;
  logic        done;
  logic [63:0] hilo;

  int checks;
  int failures;
  int n;
  logic [63:0] prev;

  hilo_ctrl dut (
    .clk    (clk),
    .resetn (resetn),
    .req    (req),
    .op     (op),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .stall  (stall),
    .done   (done),
    .hilo   (hilo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called #1 after a rising edge; returns with the bench #1 after the edge following the done cycle.
  task automatic run_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                        output int cnt);
    req = 1'b1;
    op  = o;
    a   = av;
    b   = bv;
    cnt = 0;
    #1;
    while (stall && cnt < 100) begin
      cnt++;
      @(posedge clk);
      #1;
    end
    check("no_timeout", 64'(cnt < 100), 64'd1);
    check("done_pulse", 64'(done), 64'd1);
    req = 1'b0;
    @(posedge clk);
    #1;
    check("done_clear", 64'(done), 64'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    resetn   = 1'b0;
    req      = 1'b0;
    op       = 3'd0;
    a        = 32'd0;
    b        = 32'd0;
    flush    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hilo",  hilo,         64'd0);
    check("rst_stall", 64'(stall),   64'd0);
    check("rst_done",  64'(done),    64'd0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    req = 1'b1; op = 3'd4; a = 32'h12345678;
    #1;
    check("mthi_stall", 64'(stall), 64'd0);
    @(posedge clk);
    #1;
    op = 3'd5; a = 32'h9ABCDEF0;
    #1;
    check("mtlo_stall", 64'(stall), 64'd0);
    check("mthi_hilo", hilo, 64'h12345678_00000000);
    @(posedge clk);
    #1;
    req = 1'b0;
    check("mtlo_hilo", hilo, 64'h12345678_9ABCDEF0);
    check("mt_done", 64'(done), 64'd0);

    req = 1'b1; op = 3'd6; a = 32'hDEADBEEF;
    #1;
    check("op6_stall", 64'(stall), 64'd0);
    @(posedge clk);
    #1;
    req = 1'b0;
    check("op6_hilo", hilo, 64'h12345678_9ABCDEF0);
    check("op6_done", 64'(done), 64'd0);

    run_op(3'd0, 32'hFFFFFFFE, 32'd3, n);
    check("mult_stalls", 64'(n), 64'd2);
    check("mult_hilo", hilo, 64'hFFFFFFFF_FFFFFFFA);

    run_op(3'd1, 32'hFFFFFFFE, 32'd3, n);
    check("multu_stalls", 64'(n), 64'd2);
    check("multu_hilo", hilo, 64'h00000002_FFFFFFFA);

    run_op(3'd2, 32'hFFFFFFF9, 32'd2, n);
    check("div_stalls", 64'(n), 64'd33);
    check("div_hilo", hilo, 64'hFFFFFFFF_FFFFFFFD);

    run_op(3'd3, 32'd100, 32'd7, n);
    check("divu_stalls", 64'(n), 64'd33);
    check("divu_hilo", hilo, 64'h00000002_0000000E);

    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, n);
    check("div_ovf_hilo", hilo, 64'h00000000_80000000);

    run_op(3'd3, 32'd5, 32'd0, n);
`ifdef DIV_ZERO_FAST_EN
    check("divz_stalls", 64'(n), 64'd1);
    check("divz_hilo", hilo, 64'h00000000_80000000);
    prev = 64'h00000000_80000000;
`else
    check("divz_stalls", 64'(n), 64'd33);
    check("divz_hilo", hilo, 64'h00000005_FFFFFFFF);
    prev = 64'h00000005_FFFFFFFF;
`endif

    req = 1'b1; op = 3'd2; a = 32'hFFFFFFF9; b = 32'd2;
    repeat (11) @(posedge clk);
    #1;
    flush = 1'b1;
    #1;
    check("flush_stall", 64'(stall), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    req   = 1'b0;
    #1;
    check("flush_idle", 64'(stall), 64'd0);
    check("flush_done", 64'(done), 64'd0);
    check("flush_hilo", hilo, prev);
    @(posedge clk);
    #1;
    check("flush_done2", 64'(done), 64'd0);
    check("flush_hilo2", hilo, prev);

    run_op(3'd0, 32'd5, 32'd6, n);
    check("postflush_stalls", 64'(n), 64'd2);
    check("postflush_hilo", hilo, 64'd30);

    req = 1'b1; op = 3'd0; a = 32'd7; b = 32'd9;
    #1;
    @(posedge clk);
    #1;
    req    = 1'b0;
    resetn = 1'b0;
    #1;
    check("midrst_hilo",  hilo,       64'd0);
    check("midrst_stall", 64'(stall), 64'd0);
    check("midrst_done",  64'(done),  64'd0);
    @(posedge clk);
    #1;
    check("midrst_done2", 64'(done), 64'd0);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    run_op(3'd0, 32'd3, 32'd4, n);
    check("postrst_stalls", 64'(n), 64'd2);
    check("postrst_hilo", hilo, 64'd12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/hilo_ctrl.md
# hilo_ctrl

Sequencing controller for the HI/LO register pair and the multi-cycle multiply/divide resource in the execute stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from EX and runs a 2-cycle multiply or a radix-2 iterative divide. It stalls the pipeline while an operation is in flight and owns the architectural 64-bit HILO value that the ALU reads for MFHI/MFLO.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock; all state on rising edge
- resetn  in  1  reset, asynchronous and active-low
- req  in  1  EX holds a HILO-class instruction; held high while stalled
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 ignored (no effect, no stall)
- a  in  32  rs operand (dividend / multiplicand / MTHI-MTLO source)
- b  in  32  rt operand (divisor / multiplier)
- flush  in  1  synchronous kill of in-flight or offered operation (exception/ERET)
- stall  out  1  combinational; freeze IF..EX this cycle
- done  out  1  registered; one-cycle pulse in the cycle after HILO is written by mul/div
- hilo  out  64  registered {HI, LO}

## Operation
- States: IDLE, MUL, DIV.
- Accept condition: state==IDLE && req && !done && !flush.
- MTHI/MTLO: on accept, write hilo[63:32] or hilo[31:0] from a at that edge; stay IDLE; no stall; done not pulsed.
- MULT/MULTU: on accept, latch a/b and signedness, go to MUL. In MUL, form the 64-bit product (signed or unsigned), write hilo, set done, go to IDLE.
- DIV/DIVU: on accept, latch |a|, |b| (signed op) or a, b, latch sign bits, clear 5-bit counter, go to DIV. Each DIV cycle performs one restoring step on a 64-bit {rem, quot} shift register. The 32nd step (counter==31) applies signs and writes HI=remainder, LO=quotient, sets done, and goes to IDLE.
- Signed fixup: quotient negated if a[31]^b[31]; remainder negated if a[31]. 0x80000000 / 0xFFFFFFFF yields LO=0x80000000, HI=0.
- stall = (req && op in {0..3} && state==IDLE && !done) || state!=IDLE. Stall is low whenever flush is high.
- done is cleared the cycle after it is set. Because done blocks acceptance, the still-held req is not re-issued.
- flush: state goes to IDLE, done clears, counter clears, and the in-flight result is discarded (hilo unchanged). A same-cycle MTHI/MTLO is not written.
- Reset values: hilo=0, state IDLE, done=0, counter=0. With req low, stall=0.

## Timing
- MTHI/MTLO: written at the end of request cycle C0; the new value is visible on hilo in C1.
- Multiply: request in C0 (stall=1), MUL in C1 (stall=1), hilo updated at end of C1, C2 done=1 and stall=0, EX advances. 2 stall cycles.
- Divide: request in C0, DIV in C1..C32, hilo updated at end of C32, C33 done=1 and stall=0. 33 stall cycles.
- Back-to-back: the next HILO op arriving in EX the cycle after done is accepted that cycle.
- Reset mid-operation: immediate return to reset values, asynchronous.

## Configuration
- DIV_ZERO_FAST_EN defined: DIV/DIVU with b==0 is accepted but completes in one cycle. It goes to IDLE without entering DIV, leaves hilo unchanged, and pulses done next cycle (1 stall cycle).
- Not defined: divide-by-zero runs the full 33 cycles and writes the natural algorithm result. For DIVU this is LO=0xFFFFFFFF, HI=a. For DIV, the same result with signed fixup applied.

## Test plan
- Reset, then MTHI a=0x12345678 and MTLO a=0x9ABCDEF0 on consecutive cycles -> hilo=0x123456789ABCDEF0, stall never high.
- MULT a=0xFFFFFFFE (-2), b=3 -> stall for 2 cycles, hilo=0xFFFFFFFFFFFFFFFA, done pulse 1 cycle. MULTU with the same operands -> hilo=0x00000002FFFFFFFA.
- DIV a=-7 (0xFFFFFFF9), b=2 -> 33 stall cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=100, b=7 -> LO=14, HI=2.
- DIVU a=5, b=0 -> without macro: 33 stall cycles, LO=0xFFFFFFFF, HI=5. With DIV_ZERO_FAST_EN: 1 stall cycle, hilo unchanged.
- Start DIV, assert flush at iteration 10 -> stall low that cycle, state IDLE, hilo unchanged, no done pulse. An immediate new MULT completes normally.
- resetn low during MUL -> hilo=0, stall=0 (req low), done=0. After release, MULT 3x4 -> hilo=12.
